// File: rtl/mtpsa_digest_splitter.sv
// rtl/mtpsa_digest_splitter.sv - split {digest, meta} tuser into a packet stream and a digest queue
module mtpsa_digest_splitter #(
  parameter int C_AXIS_DATA_WIDTH = 256,
  parameter int C_META_WIDTH      = 40,
  parameter int DIGEST_WIDTH      = 256,
  parameter int DIG_FIFO_DEPTH    = 4
) (
  input  logic                                 axis_aclk,
  input  logic                                 axis_rst,
  input  logic [C_AXIS_DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]       s_axis_tkeep,
  input  logic [DIGEST_WIDTH+C_META_WIDTH-1:0] s_axis_tuser,
  input  logic                                 s_axis_tvalid,
  input  logic                                 s_axis_tlast,
  output logic                                 s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]       m_axis_tkeep,
  output logic [C_META_WIDTH-1:0]              m_axis_tuser,
  output logic                                 m_axis_tvalid,
  output logic                                 m_axis_tlast,
  input  logic                                 m_axis_tready,
  output logic [DIGEST_WIDTH-1:0]              m_dig_tdata,
  output logic                                 m_dig_tvalid,
  input  logic                                 m_dig_tready,
  output logic [15:0]                          dig_drop_count,
  output logic [31:0]                          pkt_count
);

  localparam int KEEP_W = C_AXIS_DATA_WIDTH / 8;
  localparam int PTR_W  = (DIG_FIFO_DEPTH > 1) ? $clog2(DIG_FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(DIG_FIFO_DEPTH + 1);

  // Bit 32 is the only live bit of the send_dig_to_cpu byte.
  localparam int DIG_BIT = 32;

  logic                         sop;
  logic [C_META_WIDTH-1:0]      meta_hold;
  logic [C_META_WIDTH-1:0]      in_meta_fwd;
  logic [C_META_WIDTH-1:0]      in_user_fwd;
  logic                         in_ready_r;
  logic                         in_accept;

  logic                         out_valid;
  logic [C_AXIS_DATA_WIDTH-1:0] out_data;
  logic [KEEP_W-1:0]            out_keep;
  logic [C_META_WIDTH-1:0]      out_user;
  logic                         out_last;
  logic                         out_load;

  logic                         skid_valid;
  logic                         skid_valid_next;
  logic [C_AXIS_DATA_WIDTH-1:0] skid_data;
  logic [KEEP_W-1:0]            skid_keep;
  logic [C_META_WIDTH-1:0]      skid_user;
  logic                         skid_last;

  logic [DIGEST_WIDTH-1:0]      dig_mem [DIG_FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr;
  logic [PTR_W-1:0]             rd_ptr;
  logic [CNT_W-1:0]             occupancy;
  logic                         push_req;
  logic                         push;
  logic                         pop;

  assign in_accept = s_axis_tvalid && in_ready_r;
  assign out_load  = !out_valid || m_axis_tready;

  // Forwarded meta: once the digest is handled here, the send-to-cpu byte is cleared.
  always_comb begin
    in_meta_fwd = s_axis_tuser[C_META_WIDTH-1:0];
    if (s_axis_tuser[DIG_BIT]) begin
      in_meta_fwd[C_META_WIDTH-1:DIG_BIT] = '0;
    end
    in_user_fwd = sop ? in_meta_fwd : meta_hold;
  end

  // SOP tracking and per-packet meta latch.
  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      sop       <= 1'b1;
      meta_hold <= '0;
    end else if (in_accept) begin
      sop <= s_axis_tlast;
      if (sop) begin
        meta_hold <= in_meta_fwd;
      end
    end
  end

  // Skid occupancy after this cycle; input ready is its registered complement.
  always_comb begin
    skid_valid_next = skid_valid;
    if (out_load) begin
      skid_valid_next = 1'b0;
    end else if (in_accept) begin
      skid_valid_next = 1'b1;
    end
  end

  // Two-entry skid buffer: output register fed from skid first, then from input.
  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      in_ready_r <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_keep   <= '0;
      out_user   <= '0;
      out_last   <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_keep  <= '0;
      skid_user  <= '0;
      skid_last  <= 1'b0;
    end else begin
      in_ready_r <= !skid_valid_next;
      skid_valid <= skid_valid_next;
      if (out_load) begin
        if (skid_valid) begin
          out_valid <= 1'b1;
          out_data  <= skid_data;
          out_keep  <= skid_keep;
          out_user  <= skid_user;
          out_last  <= skid_last;
        end else if (in_accept) begin
          out_valid <= 1'b1;
          out_data  <= s_axis_tdata;
          out_keep  <= s_axis_tkeep;
          out_user  <= in_user_fwd;
          out_last  <= s_axis_tlast;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (in_accept) begin
        skid_data <= s_axis_tdata;
        skid_keep <= s_axis_tkeep;
        skid_user <= in_user_fwd;
        skid_last <= s_axis_tlast;
      end
    end
  end

  assign s_axis_tready = in_ready_r;
  assign m_axis_tvalid = out_valid;
  assign m_axis_tdata  = out_data;
  assign m_axis_tkeep  = out_keep;
  assign m_axis_tuser  = out_user;
  assign m_axis_tlast  = out_last;

  // Fullness is judged on pre-pop occupancy, so full plus a same-cycle pop still drops.
  assign push_req = in_accept && sop && s_axis_tuser[DIG_BIT];
  assign push     = push_req && (occupancy < CNT_W'(DIG_FIFO_DEPTH));
  assign pop      = m_dig_tvalid && m_dig_tready;

  // Digest queue storage and pointers.
  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      for (int i = 0; i < DIG_FIFO_DEPTH; i++) begin
        dig_mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        dig_mem[wr_ptr] <= s_axis_tuser[DIGEST_WIDTH+C_META_WIDTH-1:C_META_WIDTH];
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Queue occupancy; push and pop together cancel.
  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      occupancy <= '0;
    end else if (push && !pop) begin
      occupancy <= occupancy + CNT_W'(1);
    end else if (pop && !push) begin
      occupancy <= occupancy - CNT_W'(1);
    end
  end

  assign m_dig_tvalid = (occupancy != '0);
  assign m_dig_tdata  = dig_mem[rd_ptr];

  // Saturating drop counter and wrapping forwarded-packet counter.
  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      dig_drop_count <= '0;
      pkt_count      <= '0;
    end else begin
      if (push_req && !push && (dig_drop_count != 16'hFFFF)) begin
        dig_drop_count <= dig_drop_count + 16'd1;
      end
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
        pkt_count <= pkt_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_mtpsa_digest_splitter.sv
// tb/tb_mtpsa_digest_splitter.sv - directed self-checking bench for mtpsa_digest_splitter
`timescale 1ns/1ps
module tb_mtpsa_digest_splitter;

  logic          axis_aclk = 1'b0;
  logic          axis_rst = 1'b1;
  logic [255:0]  s_axis_tdata = '0;
  logic [31:0]   s_axis_tkeep = '1;
  logic [295:0]  s_axis_tuser = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [255:0]  m_axis_tdata;
  logic [31:0]   m_axis_tkeep;
  logic [39:0]   m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic [255:0]  m_dig_tdata;
  logic          m_dig_tvalid;
  logic          m_dig_tready = 1'b0;
  logic [15:0]   dig_drop_count;
  logic [31:0]   pkt_count;

  int checks = 0;
  int errors = 0;
  logic [296:0] out_q [$];

  always #5 axis_aclk = ~axis_aclk;

  mtpsa_digest_splitter dut (
    .axis_aclk(axis_aclk), .axis_rst(axis_rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .m_dig_tdata(m_dig_tdata), .m_dig_tvalid(m_dig_tvalid), .m_dig_tready(m_dig_tready),
    .dig_drop_count(dig_drop_count), .pkt_count(pkt_count)
  );

  always @(posedge axis_aclk) begin
    if (!axis_rst && m_axis_tvalid && m_axis_tready) out_q.push_back({m_axis_tlast, m_axis_tuser, m_axis_tdata});
  end

  task automatic tick();
    @(posedge axis_aclk);
    #1;
  endtask

  task automatic idle_inputs();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tuser  = '0;
  endtask

  task automatic drive_beat(input logic [255:0] d, input logic [295:0] u, input logic last);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = last;
  endtask

  task automatic do_reset();
    axis_rst = 1'b1;
    idle_inputs();
    m_axis_tready = 1'b1;
    m_dig_tready  = 1'b0;
    tick();
    tick();
    axis_rst = 1'b0;
    tick();
    out_q.delete();
  endtask

  task automatic test_reset();
    axis_rst = 1'b1;
    idle_inputs();
    m_axis_tready = 1'b0;
    tick();
    tick();
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_s_tready got %0h exp 0", s_axis_tready); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid got %0h exp 0", m_axis_tvalid); end
    checks++; if (m_dig_tvalid !== 1'b0) begin errors++; $display("FAIL rst_dig_tvalid got %0h exp 0", m_dig_tvalid); end
    checks++; if (m_axis_tdata !== 256'h0) begin errors++; $display("FAIL rst_m_tdata got %h exp 0", m_axis_tdata); end
    checks++; if (m_axis_tuser !== 40'h0) begin errors++; $display("FAIL rst_m_tuser got %h exp 0", m_axis_tuser); end
    checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_m_tlast got %0h exp 0", m_axis_tlast); end
    checks++; if (m_dig_tdata !== 256'h0) begin errors++; $display("FAIL rst_dig_tdata got %h exp 0", m_dig_tdata); end
    checks++; if (dig_drop_count !== 16'h0) begin errors++; $display("FAIL rst_drop got %0d exp 0", dig_drop_count); end
    checks++; if (pkt_count !== 32'h0) begin errors++; $display("FAIL rst_pkt got %0d exp 0", pkt_count); end
    axis_rst = 1'b0;
    tick();
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %0h exp 1", s_axis_tready); end
  endtask

  task automatic test_single_digest();
    do_reset();
    drive_beat(256'h11, {{32{8'hA5}}, 40'h01_0401_0040}, 1'b1);
    tick();
    idle_inputs();
    checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL single_tvalid got %0h exp 1", m_axis_tvalid); end
    checks++; if (m_axis_tuser !== 40'h00_0401_0040) begin errors++; $display("FAIL single_tuser got %h exp 0004010040", m_axis_tuser); end
    checks++; if (m_axis_tdata !== 256'h11) begin errors++; $display("FAIL single_tdata got %h exp 11", m_axis_tdata); end
    checks++; if (m_axis_tlast !== 1'b1) begin errors++; $display("FAIL single_tlast got %0h exp 1", m_axis_tlast); end
    checks++; if (m_axis_tkeep !== 32'hFFFF_FFFF) begin errors++; $display("FAIL single_tkeep got %h exp ffffffff", m_axis_tkeep); end
    checks++; if (m_dig_tvalid !== 1'b1) begin errors++; $display("FAIL single_dig_tvalid got %0h exp 1", m_dig_tvalid); end
    checks++; if (m_dig_tdata !== {32{8'hA5}}) begin errors++; $display("FAIL single_dig_tdata got %h exp a5..a5", m_dig_tdata); end
    tick();
    checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL single_pkt got %0d exp 1", pkt_count); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL single_tvalid_after got %0h exp 0", m_axis_tvalid); end
    m_dig_tready = 1'b1;
    tick();
    m_dig_tready = 1'b0;
    checks++; if (m_dig_tvalid !== 1'b0) begin errors++; $display("FAIL single_dig_popped got %0h exp 0", m_dig_tvalid); end
  endtask

  task automatic test_multi_beat();
    logic [296:0] b;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_beat(256'h100 + 256'(i), {256'hDEAD, 40'h00_1004_00C0}, (i == 2));
      tick();
    end
    idle_inputs();
    tick();
    tick();
    checks++; if (out_q.size() != 3) begin errors++; $display("FAIL multi_count got %0d exp 3", out_q.size()); end
    for (int k = 0; k < 3 && k < out_q.size(); k++) begin
      b = out_q[k];
      checks++; if (b[295:256] !== 40'h00_1004_00C0) begin errors++; $display("FAIL multi_tuser[%0d] got %h exp 00100400c0", k, b[295:256]); end
      checks++; if (b[255:0] !== 256'h100 + 256'(k)) begin errors++; $display("FAIL multi_tdata[%0d] got %h exp %h", k, b[255:0], 256'h100 + 256'(k)); end
      checks++; if (b[296] !== (k == 2)) begin errors++; $display("FAIL multi_tlast[%0d] got %0h exp %0h", k, b[296], (k == 2)); end
    end
    checks++; if (m_dig_tvalid !== 1'b0) begin errors++; $display("FAIL multi_no_digest got %0h exp 0", m_dig_tvalid); end
    checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL multi_pkt got %0d exp 1", pkt_count); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] held;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive_beat(256'h200 + 256'(i), {256'hD0 + 256'(i), 40'h01_0000_0040}, 1'b1);
      tick();
    end
    idle_inputs();
    tick();
    tick();
    checks++; if (dig_drop_count !== 16'd2) begin errors++; $display("FAIL b2b_drop got %0d exp 2", dig_drop_count); end
    checks++; if (pkt_count !== 32'd6) begin errors++; $display("FAIL b2b_pkt got %0d exp 6", pkt_count); end
    checks++; if (out_q.size() != 6) begin errors++; $display("FAIL b2b_beats got %0d exp 6", out_q.size()); end
    held = m_dig_tdata;
    tick();
    checks++; if (m_dig_tdata !== held || m_dig_tdata !== 256'hD0) begin errors++; $display("FAIL b2b_dig_stable got %h exp d0", m_dig_tdata); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (m_dig_tvalid !== 1'b1) begin errors++; $display("FAIL b2b_dig_tvalid[%0d] got %0h exp 1", k, m_dig_tvalid); end
      checks++; if (m_dig_tdata !== 256'hD0 + 256'(k)) begin errors++; $display("FAIL b2b_dig_tdata[%0d] got %h exp %h", k, m_dig_tdata, 256'hD0 + 256'(k)); end
      m_dig_tready = 1'b1;
      tick();
      m_dig_tready = 1'b0;
    end
    checks++; if (m_dig_tvalid !== 1'b0) begin errors++; $display("FAIL b2b_dig_empty got %0h exp 0", m_dig_tvalid); end
  endtask

  task automatic test_full_pop_drop();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_beat(256'h500 + 256'(i), {256'hE0 + 256'(i), 40'h01_0000_0040}, 1'b1);
      tick();
    end
    drive_beat(256'h504, {256'hE4, 40'h01_0000_0040}, 1'b1);
    m_dig_tready = 1'b1;
    tick();
    m_dig_tready = 1'b0;
    idle_inputs();
    checks++; if (dig_drop_count !== 16'd1) begin errors++; $display("FAIL fullpop_drop got %0d exp 1", dig_drop_count); end
    for (int k = 1; k < 4; k++) begin
      checks++; if (m_dig_tvalid !== 1'b1) begin errors++; $display("FAIL fullpop_tvalid[%0d] got %0h exp 1", k, m_dig_tvalid); end
      checks++; if (m_dig_tdata !== 256'hE0 + 256'(k)) begin errors++; $display("FAIL fullpop_tdata[%0d] got %h exp %h", k, m_dig_tdata, 256'hE0 + 256'(k)); end
      m_dig_tready = 1'b1;
      tick();
      m_dig_tready = 1'b0;
    end
    checks++; if (m_dig_tvalid !== 1'b0) begin errors++; $display("FAIL fullpop_occ3 got %0h exp 0", m_dig_tvalid); end
  endtask

  task automatic test_backpressure();
    int sent;
    int cyc;
    logic rdy;
    logic hold_v;
    logic [255:0] hold_d;
    logic [296:0] b;
    do_reset();
    sent = 0;
    cyc = 0;
    while (cyc < 240 && (sent < 10 || cyc < 60)) begin
      if (sent < 10) drive_beat(256'h300 + 256'(sent), {256'hBEEF, 40'h00_AA00_0010}, (sent == 9));
      else idle_inputs();
      m_axis_tready = (cyc % 2 == 0);
      rdy = s_axis_tready && s_axis_tvalid;
      hold_v = m_axis_tvalid && !m_axis_tready;
      hold_d = m_axis_tdata;
      tick();
      cyc++;
      if (rdy) sent++;
      if (hold_v) begin
        checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== hold_d) begin errors++; $display("FAIL bp_hold got v=%0h d=%h exp v=1 d=%h", m_axis_tvalid, m_axis_tdata, hold_d); end
      end
      checks++; if (dut.skid_valid && s_axis_tready) begin errors++; $display("FAIL bp_ready_with_skid got 1 exp 0"); end
    end
    idle_inputs();
    m_axis_tready = 1'b1;
    tick();
    tick();
    checks++; if (sent != 10) begin errors++; $display("FAIL bp_timeout got %0d exp 10", sent); end
    checks++; if (out_q.size() != 10) begin errors++; $display("FAIL bp_count got %0d exp 10", out_q.size()); end
    for (int k = 0; k < 10 && k < out_q.size(); k++) begin
      b = out_q[k];
      checks++; if (b[255:0] !== 256'h300 + 256'(k) || b[295:256] !== 40'h00_AA00_0010 || b[296] !== (k == 9)) begin
        errors++; $display("FAIL bp_beat[%0d] got %h/%h/%0h exp %h/00aa000010/%0h", k, b[255:0], b[295:256], b[296], 256'h300 + 256'(k), (k == 9));
      end
    end
    checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL bp_pkt got %0d exp 1", pkt_count); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    m_axis_tready = 1'b0;
    drive_beat(256'h600, {256'hF1, 40'h01_0000_0100}, 1'b0);
    tick();
    drive_beat(256'h601, {256'hF1, 40'h01_0000_0100}, 1'b0);
    tick();
    axis_rst = 1'b1;
    drive_beat(256'h602, {256'hF1, 40'h01_0000_0100}, 1'b0);
    tick();
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid got %0h exp 0", m_axis_tvalid); end
    checks++; if (m_dig_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_dig_tvalid got %0h exp 0", m_dig_tvalid); end
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %0h exp 0", s_axis_tready); end
    checks++; if (m_axis_tdata !== 256'h0 || m_axis_tuser !== 40'h0) begin errors++; $display("FAIL midrst_data got %h/%h exp 0/0", m_axis_tdata, m_axis_tuser); end
    checks++; if (pkt_count !== 32'd0 || dig_drop_count !== 16'd0) begin errors++; $display("FAIL midrst_counters got %0d/%0d exp 0/0", pkt_count, dig_drop_count); end
    axis_rst = 1'b0;
    idle_inputs();
    m_axis_tready = 1'b1;
    tick();
    drive_beat(256'h700, {256'hF2, 40'h01_2233_4444}, 1'b0);
    tick();
    checks++; if (m_axis_tuser !== 40'h00_2233_4444) begin errors++; $display("FAIL midrst_sop_tuser got %h exp 0022334444", m_axis_tuser); end
    checks++; if (m_dig_tvalid !== 1'b1 || m_dig_tdata !== 256'hF2) begin errors++; $display("FAIL midrst_sop_digest got %0h/%h exp 1/f2", m_dig_tvalid, m_dig_tdata); end
    drive_beat(256'h701, {256'hF3, 40'h01_5555_5555}, 1'b1);
    tick();
    idle_inputs();
    checks++; if (m_axis_tuser !== 40'h00_2233_4444 || m_axis_tlast !== 1'b1) begin errors++; $display("FAIL midrst_hold_tuser got %h/%0h exp 0022334444/1", m_axis_tuser, m_axis_tlast); end
    m_dig_tready = 1'b1;
    tick();
    m_dig_tready = 1'b0;
    checks++; if (m_dig_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_nonsop_push got %0h exp 0", m_dig_tvalid); end
  endtask

  initial begin
    test_reset();
    test_single_digest();
    test_multi_beat();
    test_back_to_back();
    test_full_pop_drop();
    test_backpressure();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mtpsa_digest_splitter.md
# mtpsa_digest_splitter

Downstream stage of each MTPSA user SDNet pipeline (user0..user7). Receives the user pipeline's packet stream, whose tuser carries {256-bit digest, 40-bit metadata}, and splits it. The packet continues to the output arbiter with a 40-bit tuser. The digest goes into a 4-deep digest queue toward the DMA/CPU path, but only when the packet's send_dig_to_cpu bit is set. Digests that overflow the queue are dropped, and the drop is counted.

## Interface
- C_AXIS_DATA_WIDTH, 256, packet data width (in and out)
- C_META_WIDTH, 40, metadata width: [15:0] pkt_len, [23:16] src_port, [31:24] dst_port, [39:32] send_dig_to_cpu (bit 32 only)
- DIGEST_WIDTH, 256, digest width; input tuser width = DIGEST_WIDTH + C_META_WIDTH
- DIG_FIFO_DEPTH, 4, digest queue entries (power of two)

Ports:
- axis_aclk  in  1  single clock for all logic
- axis_rst  in  1  reset, synchronous, active-high
- s_axis_tdata  in  C_AXIS_DATA_WIDTH  packet data from the user pipeline
- s_axis_tkeep  in  C_AXIS_DATA_WIDTH/8  byte enables
- s_axis_tuser  in  DIGEST_WIDTH+C_META_WIDTH  {digest, meta}; sampled on the SOP beat only
- s_axis_tvalid  in  1; s_axis_tlast  in  1; s_axis_tready  out  1
- m_axis_tdata  out  C_AXIS_DATA_WIDTH; m_axis_tkeep  out  C_AXIS_DATA_WIDTH/8
- m_axis_tuser  out  C_META_WIDTH  SOP metadata, held on every beat of the packet
- m_axis_tvalid  out  1; m_axis_tlast  out  1; m_axis_tready  in  1
- m_dig_tdata  out  DIGEST_WIDTH  head of the digest queue
- m_dig_tvalid  out  1  queue not empty; m_dig_tready  in  1  pop
- dig_drop_count  out  16  digests dropped because the queue was full; saturates at 0xFFFF
- pkt_count  out  32  packets forwarded (counted on the tlast handshake at m_axis); wraps

## Operation
- SOP tracking: register sop, reset value 1.
  - Cleared on an accepted s_axis beat with tlast=0.
  - Set on an accepted beat with tlast=1.
  - A single-beat packet keeps sop=1.
- On the accepted SOP beat:
  - Latch meta = s_axis_tuser[C_META_WIDTH-1:0] into meta_hold.
  - The forwarded meta has bits [39:32] forced to 0 whenever bit 32 was 1, i.e. the digest has been handled here.
  - Forwarded tuser on the SOP beat comes combinationally from the input meta (with the same clearing). Non-SOP beats carry meta_hold.
- Digest push: on the accepted SOP beat with s_axis_tuser[32]=1:
  - If the registered occupancy < DIG_FIFO_DEPTH, write s_axis_tuser[DIGEST_WIDTH+C_META_WIDTH-1:C_META_WIDTH] to the queue.
  - Otherwise discard it and increment dig_drop_count (saturating).
  - Fullness uses the occupancy before any same-cycle pop, so full + simultaneous pop still drops.
- Digest pop: m_dig_tvalid && m_dig_tready.
  - A simultaneous push and pop (occupancy < depth) leaves occupancy unchanged.
  - Pointers wrap modulo DIG_FIFO_DEPTH.
- A digest push never stalls the packet path. A full digest queue never deasserts s_axis_tready.
- Packet path is a 2-entry skid buffer: main output register plus one skid register.
  - s_axis_tready is registered and equals "skid register empty".
  - Beats are forwarded in order, with no loss or duplication.
  - tdata, tkeep, tlast and tuser are never altered except the tuser[39:32] clearing above.
- pkt_count increments on m_axis_tvalid && m_axis_tready && m_axis_tlast.

## Timing
- Reset values:
  - s_axis_tready=0, then 1 on the first cycle after axis_rst deasserts.
  - m_axis_tvalid=0, m_dig_tvalid=0.
  - m_axis_tdata/tkeep/tuser/tlast=0, m_dig_tdata=0.
  - dig_drop_count=0, pkt_count=0, occupancy=0, sop=1.
- Packet latency: a beat accepted at cycle N appears on m_axis at cycle N+1 if the output register is free. Sustained throughput is 1 beat/cycle while m_axis_tready=1.
- Backpressure:
  - When m_axis_tready drops with the output register full, the next accepted beat goes to skid.
  - s_axis_tready falls the following cycle.
  - After m_axis_tready returns, skid drains first and s_axis_tready rises one cycle later.
- Digest latency: a push at cycle N gives m_dig_tvalid=1 at N+1 with data visible. The queue is FWFT from registered storage.
- m_dig_tdata is stable while m_dig_tvalid=1 and m_dig_tready=0.
- Reset mid-packet: all in-flight beats and queued digests are discarded, sop returns to 1, and the counters clear. The first post-reset beat is treated as SOP.

## Test plan
- 1-beat packet, meta=0x01_04_01_0040, digest=0xA5..A5, tready=1 → m_axis beat at N+1 with tuser=0x00_04_01_0040; m_dig_tvalid at N+1 with 0xA5..A5; pkt_count=1.
- 3-beat packet, bit32=0, meta=0x00_10_04_00C0 → all 3 beats carry tuser 0x00_10_04_00C0; no digest push; occupancy stays 0.
- 6 back-to-back 1-beat packets, bit32=1, m_dig_tready=0 → 4 digests queued in order; dig_drop_count=2; all 6 packets forwarded; pkt_count=6.
- Queue full + m_dig_tready=1 in the same cycle as a digest SOP → the pop occurs and the new digest is dropped; occupancy 3; dig_drop_count +1.
- m_axis_tready toggled 1/0 every cycle during a 10-beat stream → every beat is output exactly once in order; s_axis_tready never high while skid is full; no tvalid drop without a handshake.
- axis_rst pulsed during beat 2 of a 4-beat packet → all outputs at reset values; the next input beat is treated as SOP and its meta is latched.
